// File: rtl/conv2d_stream_engine_pkg.sv
// Shared types and constants for the streaming 3x3 convolution engine.
package conv2d_pkg;

    typedef enum logic [1:0] {
        KSEL_SOBEL_X = 2'd0,
        KSEL_SOBEL_Y = 2'd1,
        KSEL_PROG    = 2'd2
    } kernel_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int NTAPS = 9;

    // Row-major taps, index 0 is the top-left (oldest row, oldest column).
    localparam int SOBEL_X [NTAPS] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    localparam int SOBEL_Y [NTAPS] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};

    function automatic int min_out_w(input int pix_w, input int coef_w);
        return pix_w + coef_w + 4;
    endfunction

endpackage

// File: rtl/conv2d_stream_engine_if.sv
// Pixel-in / result-out ready-valid streams of the convolution engine.
interface conv2d_stream_engine_if #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 22
);
    logic                    pixel_valid;
    logic                    pixel_ready;
    logic [PIX_W-1:0]        pixel_in;
    logic signed [OUT_W-1:0] result_out;
    logic                    result_valid;
    logic                    result_ready;

    modport slave (
        input  pixel_valid, pixel_in, result_ready,
        output pixel_ready, result_out, result_valid
    );

    modport master (
        output pixel_valid, pixel_in, result_ready,
        input  pixel_ready, result_out, result_valid
    );
endinterface

// File: rtl/conv2d_stream_engine_line_buffer.sv
// Two row FIFOs indexed by column: returns rows r-1 and r-2 at the current column.
module conv_line_buffer #(
    parameter  int IMG_W = 32,
    parameter  int PIX_W = 8,
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [COL_W-1:0] addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] row_m1,
    output logic [PIX_W-1:0] row_m2
);
    logic [PIX_W-1:0] mem_m1 [IMG_W];
    logic [PIX_W-1:0] mem_m2 [IMG_W];

    assign row_m1 = mem_m1[addr];
    assign row_m2 = mem_m2[addr];

    // NOTE: storage arrays carry no reset; their contents are overwritten before use each frame.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_m1[addr] <= din;
            mem_m2[addr] <= mem_m1[addr];
        end
    end
endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 convolution: FSM, raster counters, window, MAC and output register.
module conv2d_stream_engine
    import conv2d_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 4,
    parameter int OUT_W  = 22
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_signal,
    input  logic [1:0]               kernel_sel,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    conv2d_stream_engine_if.slave    bus,
    output logic                     done_signal,
    output logic                     busy
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    if (OUT_W < min_out_w(PIX_W, COEF_W)) begin : g_out_w_check
        $error("conv2d_stream_engine: OUT_W too narrow for PIX_W/COEF_W");
    end
    if (IMG_W < 3 || IMG_H < 3) begin : g_size_check
        $error("conv2d_stream_engine: image must be at least 3x3");
    end

    typedef logic signed [COEF_W-1:0] coef_t;

    state_e            state, state_nxt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    coef_t             coef_q   [NTAPS];
    coef_t             coef_nxt [NTAPS];
    coef_t             kern_q   [NTAPS];
    coef_t             kern_nxt [NTAPS];
    logic [PIX_W-1:0]  win      [3][2];
    logic [PIX_W-1:0]  new_col  [3];
    logic [PIX_W-1:0]  taps     [NTAPS];
    logic [PIX_W-1:0]  lb_m1, lb_m2;
    logic signed [OUT_W-1:0] mac;
    logic accept, res_take, last_px, in_window, start_now;

    assign accept    = bus.pixel_valid && bus.pixel_ready;
    assign res_take  = bus.result_valid && bus.result_ready;
    assign last_px   = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
    assign in_window = (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign start_now = (state == IDLE) && start_signal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_signal)     state_nxt = RUN;
            RUN:     if (accept && last_px) state_nxt = DRAIN;
            DRAIN:   if (res_take)         state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.pixel_ready = 1'b0;
        done_signal     = 1'b0;
        busy            = 1'b0;
        case (state)
            RUN: begin
                bus.pixel_ready = !bus.result_valid || bus.result_ready;
                busy            = 1'b1;
            end
            DRAIN: begin
                done_signal = res_take;
                busy        = 1'b1;
            end
            default: ;
        endcase
    end

    // A coefficient write in the start cycle lands before the kernel snapshot.
    always_comb begin
        coef_nxt = coef_q;
        if (state == IDLE && coef_we && coef_addr < 4'd9) coef_nxt[coef_addr] = coef_data;
        for (int k = 0; k < NTAPS; k++) begin
            case (kernel_sel_e'(kernel_sel))
                KSEL_SOBEL_Y: kern_nxt[k] = coef_t'(SOBEL_Y[k]);
                KSEL_PROG:    kern_nxt[k] = coef_nxt[k];
                default:      kern_nxt[k] = coef_t'(SOBEL_X[k]);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                coef_q[k] <= '0;
                kern_q[k] <= '0;
            end
        end else begin
            coef_q <= coef_nxt;
            if (start_now) kern_q <= kern_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col              <= '0;
            row              <= '0;
            bus.result_out   <= '0;
            bus.result_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (col == COL_W'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            if (accept && in_window) begin
                bus.result_out   <= mac;
                bus.result_valid <= 1'b1;
            end else if (res_take) begin
                bus.result_valid <= 1'b0;
            end
        end
    end

    conv_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_line_buffer (
        .clk    (clk),
        .we     (accept),
        .addr   (col),
        .din    (bus.pixel_in),
        .row_m1 (lb_m1),
        .row_m2 (lb_m2)
    );

    // Only the two older window columns are stored; the newest comes straight from the inputs.
    always_comb begin
        new_col[0] = lb_m2;
        new_col[1] = lb_m1;
        new_col[2] = bus.pixel_in;
        for (int i = 0; i < 3; i++) begin
            taps[3*i]     = win[i][0];
            taps[3*i + 1] = win[i][1];
            taps[3*i + 2] = new_col[i];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= new_col[i];
            end
        end
    end

    // NOTE: blocking assignments accumulate within combinational logic; registers use <= only.
    always_comb begin
        mac = '0;
        for (int k = 0; k < NTAPS; k++) begin
            mac = mac + OUT_W'(signed'({1'b0, taps[k]})) * OUT_W'(kern_q[k]);
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench: full frames on a 32x32 engine plus an 8x6 instance for the small-frame case.
module tb_conv2d_stream_engine;
    localparam int W = 32, H = 32, OW = W - 2, OH = H - 2;
    localparam int SW = 8, SH = 6;
    localparam int P_VEDGE = 0, P_CHECK = 1, P_HEDGE = 2, P_RAMP = 3;

    typedef struct {
        int tid;
        int r;
        int c;
        int exp;
    } spot_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_signal = 1'b0, s_start = 1'b0;
    logic [1:0] kernel_sel = 2'd0, s_ksel = 2'd0;
    logic coef_we = 1'b0, s_coef_we = 1'b0;
    logic [3:0] coef_addr = 4'd0, s_coef_addr = 4'd0;
    logic signed [3:0] coef_data = 4'sd0, s_coef_data = 4'sd0;
    logic done_signal, busy, s_done, s_busy;

    conv2d_stream_engine_if #(.PIX_W(8), .OUT_W(22)) big_if ();
    conv2d_stream_engine_if #(.PIX_W(8), .OUT_W(22)) s_if ();

    conv2d_stream_engine dut (
        .clk(clk), .rst_n(rst_n), .start_signal(start_signal), .kernel_sel(kernel_sel),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .bus(big_if), .done_signal(done_signal), .busy(busy)
    );

    conv2d_stream_engine #(.IMG_W(SW), .IMG_H(SH)) dut_s (
        .clk(clk), .rst_n(rst_n), .start_signal(s_start), .kernel_sel(s_ksel),
        .coef_we(s_coef_we), .coef_addr(s_coef_addr), .coef_data(s_coef_data),
        .bus(s_if), .done_signal(s_done), .busy(s_busy)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int got [OW*OH];
    int nres, ndone;
    bit aborted;
    spot_t spots [17];

    int KX [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    int KY [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
    int KI [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int K8 [9] = '{-8, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic check(input string name, input longint actual, input longint expected);
        vec_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int pix(input int pat, input int x, input int y);
        case (pat)
            P_VEDGE: return (x < 16) ? 0 : 255;
            P_CHECK: return ((x + y) % 2 != 0) ? 0 : 255;
            P_HEDGE: return (y < 16) ? 0 : 255;
            default: return (x + 3 * y) & 255;
        endcase
    endfunction

    function automatic int conv_ref(input int pat, input int k [9], input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += k[3*i + j] * pix(pat, c + j, r + i);
        return s;
    endfunction

    task automatic write_coef(input logic [3:0] addr, input int data);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = addr; coef_data = 4'(data);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Drives one frame on the 32x32 engine; results land in got[], pulses in ndone.
    task automatic run_frame(input int pat, input logic [1:0] ksel, input bit bp, input int abort_at,
                             input bit start_we, input logic [3:0] start_addr, input int start_data,
                             input bit poke);
        int acc = 0, cyc = 0, tail = -1, prev_out = 0, acc22 = -1, first_rv = -1;
        bit stall_prev = 1'b0;
        nres = 0; ndone = 0; aborted = 1'b0;
        @(negedge clk);
        start_signal = 1'b1; kernel_sel = ksel;
        coef_we = start_we; coef_addr = start_addr; coef_data = 4'(start_data);
        @(negedge clk);
        start_signal = 1'b0; coef_we = 1'b0;
        check("busy_in_run", busy, 1);
        while (cyc < 20000 && tail != 0) begin
            if (abort_at >= 0 && acc == abort_at) begin
                aborted = 1'b1;
                break;
            end
            big_if.pixel_valid  = (acc < W*H) && (!bp || $urandom_range(0, 1) == 1);
            big_if.pixel_in     = 8'(pix(pat, acc % W, acc / W));
            big_if.result_ready = !bp || (cyc % 3 == 0);
            coef_we = poke && acc >= 300 && acc < 310; coef_addr = 4'd4; coef_data = 4'sd5;
            #1;
            if (stall_prev) check("stall_result_stable", big_if.result_out, prev_out);
            if (big_if.result_valid && !big_if.result_ready)
                check("stall_pixel_ready", big_if.pixel_ready, 0);
            if (big_if.result_valid && first_rv < 0) first_rv = cyc;
            if (big_if.result_valid && big_if.result_ready) begin
                if (nres < OW*OH) got[nres] = big_if.result_out;
                nres++;
            end
            if (done_signal) begin
                ndone++;
                if (tail < 0) tail = 4;
            end
            if (big_if.pixel_valid && big_if.pixel_ready) begin
                if (acc == 2*W + 2) acc22 = cyc;
                acc++;
            end
            stall_prev = big_if.result_valid && !big_if.result_ready;
            prev_out   = big_if.result_out;
            @(negedge clk);
            cyc++;
            if (tail > 0) tail--;
        end
        coef_we = 1'b0;
        big_if.pixel_valid = 1'b0;
        if (!aborted) begin
            check("frame_in_budget", cyc < 20000, 1);
            check("result_count", nres, OW*OH);
            check("done_pulses", ndone, 1);
            check("first_result_latency", first_rv - acc22, 1);
            check("busy_after_done", busy, 0);
        end
    endtask

    task automatic verify(input int tid, input int pat, input int k [9]);
        for (int i = 0; i < OW*OH && i < nres; i++)
            check($sformatf("t%0d_result_r%0d_c%0d", tid, i / OW, i % OW),
                  got[i], conv_ref(pat, k, i / OW, i % OW));
        foreach (spots[s])
            if (spots[s].tid == tid)
                check($sformatf("t%0d_spot_r%0d_c%0d", tid, spots[s].r, spots[s].c),
                      got[spots[s].r * OW + spots[s].c], spots[s].exp);
    endtask

    task automatic abort_and_check();
        int bad_rv = 0, bad_done = 0;
        rst_n = 1'b0;
        #1;
        check("abort_result_valid", big_if.result_valid, 0);
        check("abort_result_out", big_if.result_out, 0);
        check("abort_pixel_ready", big_if.pixel_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done_signal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            big_if.pixel_valid = 1'b1; big_if.result_ready = 1'b1;
            #1;
            if (big_if.result_valid) bad_rv++;
            if (done_signal) bad_done++;
            @(negedge clk);
        end
        big_if.pixel_valid = 1'b0;
        check("post_abort_results", bad_rv, 0);
        check("post_abort_done", bad_done, 0);
    endtask

    initial begin
        int acc, n, nd;
        spots = '{
            '{1, 0, 14, -1020}, '{1, 29, 15, -1020}, '{1, 0, 13, 0}, '{1, 12, 16, 0}, '{1, 29, 0, 0},
            '{2, 0, 0, 0}, '{2, 17, 9, 0},
            '{3, 14, 0, -1020}, '{3, 15, 29, -1020}, '{3, 13, 5, 0}, '{3, 16, 5, 0},
            '{4, 0, 0, 4}, '{4, 29, 29, 120}, '{4, 10, 5, 39},
            '{5, 0, 0, 0}, '{5, 2, 3, -72}, '{5, 29, 29, -928}
        };
        big_if.pixel_valid = 1'b0; big_if.pixel_in = '0; big_if.result_ready = 1'b0;
        s_if.pixel_valid = 1'b0; s_if.pixel_in = '0; s_if.result_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_result_valid", big_if.result_valid, 0);
        check("reset_result_out", big_if.result_out, 0);
        check("reset_pixel_ready", big_if.pixel_ready, 0);
        check("reset_done", done_signal, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;

        run_frame(P_VEDGE, 2'd0, 1'b0, -1, 1'b0, 4'd0, 0, 1'b0);
        verify(1, P_VEDGE, KX);
        run_frame(P_CHECK, 2'd0, 1'b0, -1, 1'b0, 4'd0, 0, 1'b0);
        verify(2, P_CHECK, KX);
        run_frame(P_HEDGE, 2'd1, 1'b0, -1, 1'b0, 4'd0, 0, 1'b0);
        verify(3, P_HEDGE, KY);

        write_coef(4'd4, 1);
        run_frame(P_RAMP, 2'd2, 1'b0, -1, 1'b0, 4'd0, 0, 1'b1);
        verify(4, P_RAMP, KI);
        write_coef(4'd4, 0);
        run_frame(P_RAMP, 2'd2, 1'b0, -1, 1'b1, 4'd0, -8, 1'b0);
        verify(5, P_RAMP, K8);

        run_frame(P_VEDGE, 2'd0, 1'b1, -1, 1'b0, 4'd0, 0, 1'b0);
        verify(1, P_VEDGE, KX);

        run_frame(P_VEDGE, 2'd0, 1'b0, 500, 1'b0, 4'd0, 0, 1'b0);
        check("abort_point_reached", aborted, 1);
        abort_and_check();
        run_frame(P_VEDGE, 2'd3, 1'b0, -1, 1'b0, 4'd0, 0, 1'b0);
        verify(1, P_VEDGE, KX);

        // Small frame: Sobel X over a ramp gives -8 everywhere.
        @(negedge clk);
        s_start = 1'b1; s_ksel = 2'd0;
        @(negedge clk);
        s_start = 1'b0;
        acc = 0; n = 0; nd = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            s_if.pixel_valid  = acc < SW*SH;
            s_if.pixel_in     = 8'(pix(P_RAMP, acc % SW, acc / SW));
            s_if.result_ready = 1'b1;
            #1;
            if (s_if.result_valid) begin
                n++;
                check("small_result", s_if.result_out, -8);
            end
            if (s_done) nd++;
            if (s_if.pixel_valid && s_if.pixel_ready) acc++;
            @(negedge clk);
        end
        s_if.pixel_valid = 1'b0;
        check("small_result_count", n, (SW - 2) * (SH - 2));
        check("small_done_pulses", nd, 1);
        check("small_busy_after", s_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
